// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select codes, zero-register index, hazard tag slots.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // ALU operand select codes, shared with the execute stage mux.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b01;

    // X31 reads as zero, so it never produces a value worth forwarding.
    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ex_tag_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } mem_tag_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
    } wb_tag_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ALU source: picks EX/MEM, write-back or register file.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: src (source register of the EX instruction), mem_* (MEM slot tag), wb_* (WB slot tag),
//        sel (2-bit operand select).
module fwd_select
    import pipe_pkg::FWD_RF;
    import pipe_pkg::FWD_EXMEM;
    import pipe_pkg::FWD_WB;
#(
    parameter logic [4:0] XZR = pipe_pkg::XZR
) (
    input  logic [4:0] src,
    input  logic       mem_v,
    input  logic       mem_rw,
    input  logic [4:0] mem_rd,
    input  logic       wb_v,
    input  logic       wb_rw,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_v & mem_rw & (mem_rd != XZR) & (mem_rd == src);
    assign wb_hit  = wb_v  & wb_rw  & (wb_rd  != XZR) & (wb_rd  == src);

    // MEM holds the younger producer, so its value wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control: tracks dest tags through EX/MEM/WB, drives operand selects and stall.
// Latency: tags advance one stage per cycle; forwardA/B, stall are combinational in the current cycle.
// Backpressure: stall holds PC and IF/ID and puts a bubble in EX; flush squashes ID/EX and overrides stall.
// Ports: clk, reset_n (async active-low); id_* describe the instruction in ID; flush squashes it;
//        forwardA/forwardB are ALU operand selects; stall is the load-use hold; stall_count counts stall cycles.
module forward_ctrl
    import pipe_pkg::ex_tag_t;
    import pipe_pkg::mem_tag_t;
    import pipe_pkg::wb_tag_t;
    import pipe_pkg::FWD_RF;
    import pipe_pkg::FWD_EXMEM;
#(
    parameter logic [4:0]  XZR   = pipe_pkg::XZR,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    ex_tag_t  ex_q;
    mem_tag_t mem_q;
    wb_tag_t  wb_q;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_in_ex;
    logic       id_uses_load;

    // A load still in EX has no data yet; a dependent ID instruction must wait one cycle.
    assign load_in_ex   = ex_q.v & ex_q.rw & ex_q.mr & (ex_q.rd != XZR);
    assign id_uses_load = (ex_q.rd == id_rs1) | (ex_q.rd == id_rs2);
    assign stall        = ~flush & id_valid & load_in_ex & id_uses_load;

    // Tag pipeline. Only EX can take a bubble; MEM and WB always advance.
    // EX payload fields are loaded even for bubbles: v alone decides whether they count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q.v   <= id_valid & ~stall & ~flush;
            ex_q.rs1 <= id_rs1;
            ex_q.rs2 <= id_rs2;
            ex_q.rd  <= id_rd;
            ex_q.rw  <= id_reg_write;
            ex_q.mr  <= id_mem_read;
            mem_q    <= '{v: ex_q.v, rd: ex_q.rd, rw: ex_q.rw, mr: ex_q.mr};
            wb_q     <= '{v: mem_q.v, rd: mem_q.rd, rw: mem_q.rw};
        end
    end

    fwd_select #(.XZR(XZR)) u_sel_a (
        .src    (ex_q.rs1),
        .mem_v  (mem_q.v),
        .mem_rw (mem_q.rw),
        .mem_rd (mem_q.rd),
        .wb_v   (wb_q.v),
        .wb_rw  (wb_q.rw),
        .wb_rd  (wb_q.rd),
        .sel    (sel_a)
    );

    fwd_select #(.XZR(XZR)) u_sel_b (
        .src    (ex_q.rs2),
        .mem_v  (mem_q.v),
        .mem_rw (mem_q.rw),
        .mem_rd (mem_q.rd),
        .wb_v   (wb_q.v),
        .wb_rw  (wb_q.rw),
        .wb_rd  (wb_q.rd),
        .sel    (sel_b)
    );

    // A bubble in EX has stale source fields; never let them steer the mux.
    assign forwardA = ex_q.v ? sel_a : FWD_RF;
    assign forwardB = ex_q.v ? sel_b : FWD_RF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // The load-use stall keeps a load in MEM from ever being the EX/MEM forwarding source.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(mem_q.v && mem_q.mr &&
                      ((forwardA == FWD_EXMEM) || (forwardB == FWD_EXMEM))));
        end
    end

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic        stall;
    logic [15:0] stall_count;

    // Second instance with a narrow counter so saturation is reachable quickly.
    logic        s_id_valid;
    logic [1:0]  s_forwardA;
    logic [1:0]  s_forwardB;
    logic        s_stall;
    logic [3:0]  s_stall_count;

    int passed = 0;
    int total  = 0;

    forward_ctrl #(.XZR(5'd31), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .forwardA     (forwardA),
        .forwardB     (forwardB),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    // Constant LDUR X9,[X9]: depends on itself, so it stalls every other cycle.
    forward_ctrl #(.XZR(5'd31), .CNT_W(4)) u_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (s_id_valid),
        .id_rs1       (5'd9),
        .id_rs2       (5'd0),
        .id_rd        (5'd9),
        .id_reg_write (1'b1),
        .id_mem_read  (1'b1),
        .flush        (1'b0),
        .forwardA     (s_forwardA),
        .forwardB     (s_forwardB),
        .stall        (s_stall),
        .stall_count  (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one instruction in ID for the coming cycle; outputs are checked 1ns later.
    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        @(negedge clk);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n      = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_rd        = 5'd0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        flush        = 1'b0;
        s_id_valid   = 1'b0;
        #1;
        chk("reset_fwdA", 16'(forwardA), 16'h0);
        chk("reset_fwdB", 16'(forwardB), 16'h0);
        chk("reset_stall", 16'(stall), 16'h0);
        chk("reset_count", stall_count, 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // EX->EX: ADD X1,X2,X3 ; SUB X4,X1,X5
        issue(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
        issue(1, 5'd1, 5'd5, 5'd4, 1, 0, 0);
        chk("exex_add_in_ex_fwdA", 16'(forwardA), 16'h0);
        nop();
        chk("exex_fwdA", 16'(forwardA), 16'h2);
        chk("exex_fwdB", 16'(forwardB), 16'h0);
        chk("exex_stall", 16'(stall), 16'h0);

        // WB: ADD X1 ; NOP ; ORR X6,X7,X1
        issue(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
        nop();
        issue(1, 5'd7, 5'd1, 5'd6, 1, 0, 0);
        nop();
        chk("wb_fwdB", 16'(forwardB), 16'h1);
        chk("wb_fwdA", 16'(forwardA), 16'h0);

        // Priority: ADD X1 ; ADD X1 ; ADD X8,X1,X1
        issue(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
        issue(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
        issue(1, 5'd1, 5'd1, 5'd8, 1, 0, 0);
        nop();
        chk("prio_fwdA", 16'(forwardA), 16'h2);
        chk("prio_fwdB", 16'(forwardB), 16'h2);

        // Load-use: LDUR X9,[X10] ; ADD X11,X9,X12 (held one cycle by the stall)
        issue(1, 5'd10, 5'd0, 5'd9, 1, 1, 0);
        issue(1, 5'd9, 5'd12, 5'd11, 1, 0, 0);
        chk("lu_stall_on", 16'(stall), 16'h1);
        chk("lu_count_before", stall_count, 16'h0);
        issue(1, 5'd9, 5'd12, 5'd11, 1, 0, 0);
        chk("lu_stall_off", 16'(stall), 16'h0);
        chk("lu_bubble_fwdA", 16'(forwardA), 16'h0);
        chk("lu_bubble_fwdB", 16'(forwardB), 16'h0);
        chk("lu_count", stall_count, 16'h1);
        nop();
        chk("lu_consumer_fwdA", 16'(forwardA), 16'h1);
        chk("lu_consumer_fwdB", 16'(forwardB), 16'h0);
        chk("lu_consumer_stall", 16'(stall), 16'h0);

        // XZR: LDUR XZR,[X10] ; ADD X1,XZR,X2
        issue(1, 5'd10, 5'd0, 5'd31, 1, 1, 0);
        issue(1, 5'd31, 5'd2, 5'd1, 1, 0, 0);
        chk("xzr_stall", 16'(stall), 16'h0);
        nop();
        chk("xzr_fwdA", 16'(forwardA), 16'h0);
        chk("xzr_fwdB", 16'(forwardB), 16'h0);

        // Flush during load-use: LDUR X9 ; ADD X11,X12,X9 with flush
        issue(1, 5'd10, 5'd0, 5'd9, 1, 1, 0);
        issue(1, 5'd12, 5'd9, 5'd11, 1, 0, 1);
        chk("flush_stall", 16'(stall), 16'h0);
        nop();
        chk("flush_bubble_fwdB", 16'(forwardB), 16'h0);
        chk("flush_count", stall_count, 16'h1);

        // Load-use through the second operand: LDUR X9 ; STUR X9,[X13]
        issue(1, 5'd10, 5'd0, 5'd9, 1, 1, 0);
        issue(1, 5'd13, 5'd9, 5'd0, 0, 0, 0);
        chk("lu2_stall_on", 16'(stall), 16'h1);
        issue(1, 5'd13, 5'd9, 5'd0, 0, 0, 0);
        chk("lu2_stall_off", 16'(stall), 16'h0);
        chk("lu2_count", stall_count, 16'h2);
        nop();
        chk("lu2_fwdB", 16'(forwardB), 16'h1);

        // Async reset mid-stream: ADD X1 ; LDUR X4,[X1] ; ADD X5,X4,X6 (stalling)
        issue(1, 5'd2, 5'd3, 5'd1, 1, 0, 0);
        issue(1, 5'd1, 5'd0, 5'd4, 1, 1, 0);
        issue(1, 5'd4, 5'd6, 5'd5, 1, 0, 0);
        chk("pre_rst_fwdA", 16'(forwardA), 16'h2);
        chk("pre_rst_stall", 16'(stall), 16'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_fwdA", 16'(forwardA), 16'h0);
        chk("async_rst_fwdB", 16'(forwardB), 16'h0);
        chk("async_rst_stall", 16'(stall), 16'h0);
        chk("async_rst_count", stall_count, 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_stall", 16'(stall), 16'h0);
        chk("post_rst_fwdA", 16'(forwardA), 16'h0);
        nop();

        // Counter saturation on the narrow instance: stalls on every second cycle.
        @(negedge clk);
        s_id_valid = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("sat_count_mid", 16'(s_stall_count), 16'hA);
        repeat (60) @(negedge clk);
        #1;
        chk("sat_count_full", 16'(s_stall_count), 16'hF);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_count_hold", 16'(s_stall_count), 16'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
